ps2_kmouse_ext: RTL and testbench
=================================

Name: ps2_kmouse_ext

Overview:
- Parametrised PS/2-to-Kempston mouse interface; successor to the basic Kempston mouse block.
- Adds a synchronised PS/2 input, a proper bit-level receive state machine and a per-byte packet index.
- Adds a fractional-precision movement accumulator (sensitivity), a middle button, an accepted-packet strobe and an optional wheel nibble.
- Sits on the Z80 I/O decode beside the keyboard and joystick ports; drives the Kempston X, Y and button ports.

Parameters:
CNT_W, 8, accumulator width per axis, legal 8..12; the port reads bits [CNT_W-1:CNT_W-8], so sensitivity is divided by 2^(CNT_W-8).
IDLE_TICKS, 3500000, number of ce_7mp ticks with PS/2 clock high before the receiver and packet index are forced to resync.

Ports:
clk_sys  in  1  system clock; the single clock domain.
reset  in  1  synchronous, active-high reset.
ce_7mp  in  1  7 MHz clock enable; used only for the idle timer.
ps2_mouse_clk  in  1  PS/2 clock; asynchronous, 2-flop synchronised internally.
ps2_mouse_data  in  1  PS/2 data; asynchronous, 2-flop synchronised internally.
addr  in  3  port decode bits.
sel  out  1  high when addr hits a mouse port.
dout  out  8  read data, combinational from addr.
pkt_stb  out  1  one clk_sys pulse per accepted packet.

Behaviour:
- Reset values:
  - dx = 128<<(CNT_W-8); dy = 0. dx != dy is deliberate, for software detection.
  - buttons released, wheel = 0, swap unlatched, pkt_stb = 0.
  - rx state START, byte index 0, idle counter 0.
- PS/2 edge handling:
  - Falling edge = synchronised clock 1 -> 0.
  - Data is sampled on the falling edge, in the same cycle the edge is detected.
- Rx FSM, advancing one state per falling edge:
  - START: bit must be 0.
  - DATA: 8 bits, LSB first.
  - PARITY: odd parity over the 8 data bits plus the parity bit.
  - STOP: bit must be 1.
  - Any check failure -> back to START, byte index 0, partial packet discarded.
- Packet assembly:
  - Byte 0 must have bit3 = 1; otherwise discard and stay at index 0. This gives frame alignment.
  - Packet length N = 3, or 4 with the optional feature.
  - On the STOP of byte N-1, the update is applied on the following cycle and pkt_stb pulses in that same cycle. Latency from the final falling edge to the updated dout is 2 clk_sys cycles.
- Update arithmetic:
  - X delta = 9-bit signed {b0[4], b1}; Y delta = {b0[5], b2}.
  - Overflow bits b0[7:6] are ignored.
  - Each delta is sign-extended to CNT_W bits; dx += dX and dy += dY modulo 2^CNT_W (wrap-around, no clamping).
  - PS/2 +Y is up and Kempston Y increases upward, so Y is not negated.
- Buttons: L = b0[0], R = b0[1], M = b0[2], all latched every packet.
- Swap latch:
  - Set once, at the first packet with L or R pressed; swapped = R pressed in that packet.
  - It then stays fixed until reset.
- Idle timer:
  - Counts ce_7mp while the synchronised clock is high; cleared on every falling edge.
  - On reaching IDLE_TICKS: rx state -> START and byte index -> 0. Counters are untouched.
  - The timer saturates at IDLE_TICKS.
- Port decode (sel = 1 on a hit, otherwise sel = 0 and dout = FF):
  - addr = 011: dout = dx[CNT_W-1:CNT_W-8].
  - addr = 111: dout = dy[CNT_W-1:CNT_W-8].
  - addr = x10: dout = {wheel[3:0] or 1111, 1, ~M, ~B1, ~B0}. B0 = L and B1 = R when unswapped; exchanged when swapped.
- Reset mid-packet: all state returns to reset values in the same cycle; the next byte must re-align via the bit3 check.
- Simultaneous events:
  - Falling edge together with idle expiry: the edge wins and the timer clears.
  - Reset overrides everything.

Optional Feature:
- Macro KMOUSE_WHEEL_EN.
- Defined:
  - N = 4. The platform PS/2 source is in IntelliMouse mode.
  - Byte 3 bits[3:0] give a signed 4-bit z delta; wheel += z, modulo 16.
  - Button port bits 7:4 = wheel.
- Undefined:
  - N = 3; no wheel register exists.
  - Button port bits 7:4 read 1111.

Test Plan:
- Reset, then read all three ports -> X = 80, Y = 00, buttons = FF (wheel off) or 0F (wheel on); sel = 1 on each, sel = 0 / dout = FF at addr 000.
- Packet 08,05,03 (CNT_W = 8) -> X = 85, Y = 03, pkt_stb exactly 1 cycle, 2 clk_sys after the final falling edge.
- Packet 18,FE,00 twice with CNT_W = 10 -> X port reads 7F, i.e. dx = 0x1FC, showing the fractional accumulation.
- Byte 0 sent with a parity error, then a valid packet 09,00,00 -> the first is dropped; buttons read F{E|...}, i.e. bit0 = 0 (L pressed), swap unlatched -> B0 = L.
- Two bytes of a packet, clock held high for IDLE_TICKS, then a full packet 08,01,01 -> only +1/+1 applied; the stale bytes are discarded.
- KMOUSE_WHEEL_EN: packets with z = +3 then z = -5 (0xB) -> wheel nibble 3 then E; buttons read 3F then EF.

Source files
------------

// File: rtl/ps2_kmouse_ext.sv
// ps2_kmouse_ext: PS/2 mouse to Kempston X/Y/button ports with a fractional movement accumulator.
// Define KMOUSE_WHEEL_EN for 4-byte IntelliMouse packets and a wheel nibble on the button port.
module ps2_kmouse_ext #(
    parameter int CNT_W      = 8,
    parameter int IDLE_TICKS = 3500000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_7mp,
    input  logic       ps2_mouse_clk,
    input  logic       ps2_mouse_data,
    input  logic [2:0] addr,
    output logic       sel,
    output logic [7:0] dout,
    output logic       pkt_stb
);
    localparam logic [1:0] START = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
    localparam int IW = $clog2(IDLE_TICKS + 1);
`ifdef KMOUSE_WHEEL_EN
    localparam logic [1:0] LAST = 2'd3;
    logic [3:0] b3, wheel;
`else
    localparam logic [1:0] LAST = 2'd2;
`endif
    logic [2:0] clk_s, bit_cnt, btn;
    logic [1:0] dat_s, state, idx;
    logic [7:0] shreg, b1, b2;
    logic [4:0] h0;
    logic [3:0] hi;
    logic [IW-1:0] idle;
    logic [CNT_W-1:0] dx, dy;
    logic signed [8:0] ddx, ddy;
    logic par, upd, swap_set, swapped, fall, din, idle_hit, b_l, b_r;
    assign fall = clk_s[2] & ~clk_s[1];
    assign din = dat_s[1];
    assign idle_hit = idle == IW'(IDLE_TICKS);
    // h0 keeps {Y sign, X sign, M, R, L} of byte 0
    assign ddx = {h0[3], b1};
    assign ddy = {h0[4], b2};
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s <= 3'b111;
            dat_s <= 2'b11;
            state <= START;
            idx <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            par <= 1'b0;
            h0 <= '0;
            b1 <= '0;
            b2 <= '0;
            upd <= 1'b0;
            pkt_stb <= 1'b0;
            idle <= '0;
            dx <= {1'b1, {(CNT_W-1){1'b0}}};
            dy <= '0;
            btn <= '0;
            swap_set <= 1'b0;
            swapped <= 1'b0;
`ifdef KMOUSE_WHEEL_EN
            b3 <= '0;
            wheel <= '0;
`endif
        end else begin
            clk_s <= {clk_s[1:0], ps2_mouse_clk};
            dat_s <= {dat_s[0], ps2_mouse_data};
            upd <= 1'b0;
            pkt_stb <= upd;
            if (fall) idle <= '0;
            else if (clk_s[1] && ce_7mp && !idle_hit) idle <= idle + IW'(1);
            if (fall) begin
                case (state)
                    START: begin
                        state <= din ? START : DATA;
                        bit_cnt <= '0;
                        par <= 1'b0;
                        if (din) idx <= '0;
                    end
                    DATA: begin
                        shreg <= {din, shreg[7:1]};
                        par <= par ^ din;
                        bit_cnt <= bit_cnt + 3'd1;
                        state <= bit_cnt == 3'd7 ? PARITY : DATA;
                    end
                    PARITY: begin
                        state <= (par ^ din) ? STOP : START;
                        if (!(par ^ din)) idx <= '0;
                    end
                    STOP: begin
                        state <= START;
                        if (!din) idx <= '0;
                        else if (idx != 2'd0 || shreg[3]) begin
                            if (idx == 2'd0) h0 <= {shreg[5:4], shreg[2:0]};
                            if (idx == 2'd1) b1 <= shreg;
                            if (idx == 2'd2) b2 <= shreg;
`ifdef KMOUSE_WHEEL_EN
                            if (idx == 2'd3) b3 <= shreg[3:0];
`endif
                            idx <= idx == LAST ? 2'd0 : idx + 2'd1;
                            upd <= idx == LAST;
                        end
                    end
                endcase
            end else if (idle_hit) begin
                state <= START;
                idx <= '0;
            end
            if (upd) begin
                dx <= dx + CNT_W'(ddx);
                dy <= dy + CNT_W'(ddy);
                btn <= h0[2:0];
                if (!swap_set && |h0[1:0]) begin
                    swap_set <= 1'b1;
                    swapped <= h0[1];
                end
`ifdef KMOUSE_WHEEL_EN
                wheel <= wheel + b3;
`endif
            end
        end
    end
`ifdef KMOUSE_WHEEL_EN
    assign hi = wheel;
`else
    assign hi = 4'hF;
`endif
    assign b_l = swapped ? btn[1] : btn[0];
    assign b_r = swapped ? btn[0] : btn[1];
    always_comb begin
        sel = addr == 3'b011 || addr == 3'b111 || addr[1:0] == 2'b10;
        dout = addr == 3'b011 ? dx[CNT_W-1 -: 8] :
               addr == 3'b111 ? dy[CNT_W-1 -: 8] :
               addr[1:0] == 2'b10 ? {hi, 1'b1, ~btn[2], ~b_r, ~b_l} : 8'hFF;
    end
endmodule

// File: tb/tb_ps2_kmouse_ext.sv
// tb_ps2_kmouse_ext: directed PS/2 packets into an 8-bit and a 10-bit accumulator instance.
`timescale 1ns/1ps
module tb_ps2_kmouse_ext;
    logic clk_sys = 1'b0, reset = 1'b1, ce_7mp = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [2:0] addr = 3'd0;
    logic sel, sel10, pkt_stb, stb10;
    logic [7:0] dout, dout10;
    int n_cmp = 0, n_bad = 0, cyc = 0, last_fall = 0, stb_cyc = 0, stb_cnt = 0, s0;
`ifdef KMOUSE_WHEEL_EN
    localparam logic [3:0] HI0 = 4'h0;
`else
    localparam logic [3:0] HI0 = 4'hF;
`endif
    ps2_kmouse_ext #(.CNT_W(8), .IDLE_TICKS(40)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_7mp(ce_7mp), .ps2_mouse_clk(ps2_clk),
        .ps2_mouse_data(ps2_data), .addr(addr), .sel(sel), .dout(dout), .pkt_stb(pkt_stb));
    ps2_kmouse_ext #(.CNT_W(10), .IDLE_TICKS(40)) dut10 (
        .clk_sys(clk_sys), .reset(reset), .ce_7mp(ce_7mp), .ps2_mouse_clk(ps2_clk),
        .ps2_mouse_data(ps2_data), .addr(addr), .sel(sel10), .dout(dout10), .pkt_stb(stb10));
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;
    always @(negedge clk_sys) begin
        if (pkt_stb) begin
            stb_cnt <= stb_cnt + 1;
            stb_cyc <= cyc;
        end
    end
    initial forever begin
        @(negedge clk_sys);
        ce_7mp = ~ce_7mp;
    end
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask
    task automatic ps2_bit(input logic b);
        @(negedge clk_sys);
        ps2_data = b;
        wait_cyc(6);
        ps2_clk = 1'b0;
        last_fall = cyc;
        wait_cyc(6);
        ps2_clk = 1'b1;
    endtask
    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(1'b1);
    endtask
    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send_byte(a, 1'b0);
        send_byte(b, 1'b0);
        send_byte(c, 1'b0);
`ifdef KMOUSE_WHEEL_EN
        send_byte(d, 1'b0);
`else
        if (d != d) send_byte(d, 1'b0);
`endif
        wait_cyc(10);
    endtask
    task automatic rd(input logic [2:0] a, input string tag, input logic [7:0] exp);
        @(negedge clk_sys);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask
    task automatic rd10(input logic [2:0] a, input string tag, input logic [7:0] exp);
        @(negedge clk_sys);
        addr = a;
        #1;
        check(tag, dout10, exp);
    endtask
    task automatic do_reset;
        @(negedge clk_sys);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(3);
    endtask
    initial begin
        do_reset();
        check("rst_stb", pkt_stb, 0);
        rd(3'b011, "rst_x", 8'h80);
        check("rst_sel_x", sel, 1);
        rd(3'b111, "rst_y", 8'h00);
        check("rst_sel_y", sel, 1);
        rd(3'b010, "rst_btn", {HI0, 4'hF});
        check("rst_sel_btn", sel, 1);
        rd(3'b110, "rst_btn_alias", {HI0, 4'hF});
        rd(3'b000, "miss_dout", 8'hFF);
        check("miss_sel", sel, 0);
        rd(3'b001, "miss_dout_001", 8'hFF);
        rd10(3'b011, "rst_x10", 8'h80);
        s0 = stb_cnt;
        send_pkt(8'h08, 8'h05, 8'h03, 8'h00);
        check("stb_cnt_basic", stb_cnt - s0, 1);
        check("stb_latency", stb_cyc - last_fall, 4);
        rd(3'b011, "basic_x", 8'h85);
        rd(3'b111, "basic_y", 8'h03);
        rd(3'b010, "basic_btn", {HI0, 4'hF});
        do_reset();
        send_pkt(8'h18, 8'hFE, 8'h00, 8'h00);
        send_pkt(8'h18, 8'hFE, 8'h00, 8'h00);
        rd10(3'b011, "frac_x10", 8'h7F);
        rd10(3'b111, "frac_y10", 8'h00);
        rd(3'b011, "frac_x8", 8'h7C);
        do_reset();
        s0 = stb_cnt;
        send_byte(8'h09, 1'b1);
        send_pkt(8'h09, 8'h00, 8'h00, 8'h00);
        check("stb_cnt_parity", stb_cnt - s0, 1);
        rd(3'b010, "btn_left", {HI0, 4'hE});
        rd(3'b011, "parity_x", 8'h80);
        send_pkt(8'h0A, 8'h00, 8'h00, 8'h00);
        rd(3'b010, "btn_right_unswapped", {HI0, 4'hD});
        send_pkt(8'h0C, 8'h00, 8'h00, 8'h00);
        rd(3'b010, "btn_middle", {HI0, 4'hB});
        do_reset();
        send_pkt(8'h0A, 8'h00, 8'h00, 8'h00);
        rd(3'b010, "btn_right_swapped", {HI0, 4'hE});
        send_pkt(8'h09, 8'h00, 8'h00, 8'h00);
        rd(3'b010, "btn_left_swapped", {HI0, 4'hD});
        do_reset();
        s0 = stb_cnt;
        send_byte(8'h08, 1'b0);
        send_byte(8'h7F, 1'b0);
        wait_cyc(120);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
        check("stb_cnt_idle", stb_cnt - s0, 1);
        rd(3'b011, "idle_x", 8'h81);
        rd(3'b111, "idle_y", 8'h01);
        do_reset();
        s0 = stb_cnt;
        send_byte(8'h01, 1'b0);
        send_pkt(8'h28, 8'h02, 8'hFF, 8'h00);
        check("stb_cnt_align", stb_cnt - s0, 1);
        rd(3'b011, "align_x", 8'h82);
        rd(3'b111, "align_y", 8'hFF);
        rd10(3'b111, "align_y10", 8'hFF);
        rd10(3'b011, "align_x10", 8'h80);
        do_reset();
        send_byte(8'h08, 1'b0);
        send_byte(8'h05, 1'b0);
        do_reset();
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
        rd(3'b011, "midreset_x", 8'h81);
        rd(3'b111, "midreset_y", 8'h01);
        do_reset();
        send_pkt(8'h08, 8'h7F, 8'h00, 8'h00);
        send_pkt(8'h08, 8'h7F, 8'h00, 8'h00);
        rd(3'b011, "wrap_x", 8'h7E);
        rd10(3'b011, "wrap_x10", 8'hBF);
`ifdef KMOUSE_WHEEL_EN
        do_reset();
        send_pkt(8'h08, 8'h00, 8'h00, 8'h03);
        rd(3'b010, "wheel_up", 8'h3F);
        send_pkt(8'h08, 8'h00, 8'h00, 8'h0B);
        rd(3'b010, "wheel_down", 8'hEF);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
